// File: rtl/mem_bus_rr_sched_if.sv
// Core-side request/response buses and the memory bus for the round-robin scheduler.
interface mem_bus_rr_sched_if #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NPORTS-1:0]        req_valid;
  logic [NPORTS-1:0]        req_ready;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS-1:0]        req_wen;
  logic [NPORTS*DATA_W-1:0] req_wdata;
  logic [NPORTS-1:0]        resp_valid;
  logic [ADDR_W-1:0]        resp_addr;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic                     mem_req_wen;
  logic [DATA_W-1:0]        mem_req_wdata;
  logic                     mem_resp_valid;
  logic [DATA_W-1:0]        mem_resp_rdata;
  logic [CW-1:0]            outstanding;
  logic                     err;

  // scheduler side
  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_addr, resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    output outstanding, err
  );

  // requesters + memory side
  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_addr, resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    input  outstanding, err
  );
endinterface

// File: rtl/mem_bus_rr_sched.sv
// Round-robin memory bus scheduler with an in-order tag FIFO for up to DEPTH
// outstanding reads; read data is routed back to the requester that issued it.

// Per-port slice: accept strobe and registered response strobe.
module mem_bus_rr_port #(
  parameter int PW  = 1,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] grant,
  input  logic          hs,
  input  logic          pop,
  input  logic [PW-1:0] head_id,
  output logic          req_ready,
  output logic          resp_valid
);
  logic resp_valid_d, resp_valid_q;

  assign req_ready = hs && (grant == PW'(IDX));

  // response strobe for this port: one cycle after the pop of its tag
  always_comb begin
    resp_valid_d = pop && (head_id == PW'(IDX));
  end

  // response strobe register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_valid_q <= 1'b0;
    else        resp_valid_q <= resp_valid_d;
  end

  assign resp_valid = resp_valid_q;
endmodule

module mem_bus_rr_sched #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  mem_bus_rr_sched_if.slave  bus
);
  localparam int PW = $clog2(NPORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PW-1:0]     id;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  logic [PW-1:0]     rr_ptr_d, rr_ptr_q;
  logic              lock_d, lock_q;
  logic [PW-1:0]     lock_id_d, lock_id_q;
  logic [AW-1:0]     wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]     rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]     count_d, count_q;
  logic [ADDR_W-1:0] resp_addr_d, resp_addr_q;
  logic [DATA_W-1:0] resp_rdata_d, resp_rdata_q;
  logic              err_d, err_q;

  tag_t              tag_mem [DEPTH];
  tag_t              head;
  tag_t              push_tag;
  logic [PW-1:0]     grant;
  logic              full, hs, push, pop, sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [NPORTS-1:0] req_ready_w, resp_valid_w;

  // (base + k) mod NPORTS
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NPORTS) s = s - NPORTS;
    return PW'(s);
  endfunction

  // grant: held port while locked, else first valid port from rr_ptr upward
  always_comb begin
    grant = lock_q ? lock_id_q : rr_ptr_q;
    if (!lock_q) begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        if (bus.req_valid[rr_idx(rr_ptr_q, k)]) grant = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign full     = (count_q == CW'(DEPTH));
  // no issue while in reset, so nothing can be accepted that the cleared FIFO would lose
  assign bus.mem_req_valid = rst_n && (|bus.req_valid) && !full;
  assign hs       = bus.mem_req_valid && bus.mem_req_ready;
  assign sel_wen  = bus.req_wen[grant];
  assign sel_addr = bus.req_addr[grant*ADDR_W +: ADDR_W];
  assign push     = hs && !sel_wen;
  assign pop      = bus.mem_resp_valid && (count_q != '0);
  assign head     = tag_mem[rd_ptr_q];
  assign push_tag = '{id: grant, addr: sel_addr};

  assign bus.mem_req_addr  = sel_addr;
  assign bus.mem_req_wen   = sel_wen;
  assign bus.mem_req_wdata = bus.req_wdata[grant*DATA_W +: DATA_W];

  // next-state: arbitration pointer, lock, tag FIFO pointers, response data, error
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    resp_addr_d  = resp_addr_q;
    resp_rdata_d = resp_rdata_q;
    err_d        = err_q;
    if (hs) begin
      rr_ptr_d = (grant == PW'(NPORTS - 1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (bus.mem_req_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      resp_addr_d  = head.addr;
      resp_rdata_d = bus.mem_resp_rdata;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.mem_resp_valid && (count_q == '0)) err_d = 1'b1;
  end

  // control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_addr_q  <= '0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_addr_q  <= resp_addr_d;
      resp_rdata_q <= resp_rdata_d;
      err_q        <= err_d;
    end
  end

  // tag storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= push_tag;
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    mem_bus_rr_port #(.PW(PW), .IDX(i)) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .grant      (grant),
      .hs         (hs),
      .pop        (pop),
      .head_id    (head.id),
      .req_ready  (req_ready_w[i]),
      .resp_valid (resp_valid_w[i])
    );
  end

  assign bus.req_ready   = req_ready_w;
  assign bus.resp_valid  = resp_valid_w;
  assign bus.resp_addr   = resp_addr_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.outstanding = count_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_mem_bus_rr_sched.sv
// Scoreboard bench for mem_bus_rr_sched: memory-side responder pushes the
// expected routed response; a negedge monitor pops and compares.
module tb_mem_bus_rr_sched;
  localparam int NP = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_rr_sched_if #(.NPORTS(NP), .DEPTH(DP), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_rr_sched #(.NPORTS(NP), .DEPTH(DP), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        tb_vld [NP];
  logic [31:0] tb_addr[NP];
  logic        tb_wen [NP];
  logic [31:0] tb_wd  [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      bus.req_valid[i]          = tb_vld[i];
      bus.req_addr[i*32 +: 32]  = tb_addr[i];
      bus.req_wen[i]            = tb_wen[i];
      bus.req_wdata[i*32 +: 32] = tb_wd[i];
    end
  end

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] issued[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          grant_log[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // response monitor + memory-side handshake recorder
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", {62'd0, bus.resp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {62'd0, bus.resp_valid}, 64'(1) << e.port);
        chk("resp_addr", bus.resp_addr, e.addr);
        chk("resp_rdata", bus.resp_rdata, e.data);
        chk("resp_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("resp_missing", 64'd0, {62'd0, 2'(1 << e.port)});
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      if (bus.mem_req_wen) begin
        wr_addr_log.push_back(bus.mem_req_addr);
        wr_data_log.push_back(bus.mem_req_wdata);
      end else begin
        issued.push_back(bus.mem_req_addr);
      end
      grant_log.push_back(bus.req_ready[1] ? 1 : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive one request on port p and hold it until accepted
  task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    bit got;
    tb_vld[p] = 1'b1; tb_addr[p] = a; tb_wen[p] = w; tb_wd[p] = d;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready[p]) begin got = 1'b1; break; end
    end
    chk("issue_accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    tb_vld[p] = 1'b0;
  endtask

  // memory returns data for the oldest issued read; the owner is encoded in addr[12]
  task automatic push_resp(input logic [31:0] d);
    logic [31:0] a;
    if (issued.size() == 0) begin
      chk("mem_model_empty", 64'd0, 64'd1);
      a = '0;
    end else begin
      a = issued.pop_front();
      sb.push_back('{port: int'(a[12]), addr: a, data: d, due: cyc + 1});
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = d;
  endtask

  task automatic respond(input logic [31:0] d);
    push_resp(d);
    step(1);
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    for (int i = 0; i < NP; i++) begin
      tb_vld[i] = 1'b0; tb_addr[i] = '0; tb_wen[i] = 1'b0; tb_wd[i] = '0;
    end
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    // reset state
    #2;
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_addr", bus.resp_addr, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // T1 single read
    issue(0, 32'h100, 1'b0, '0);
    step(1);
    respond(32'hDEADBEEF);
    step(3);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_grant0", grant_log[0], 0);

    // T2 round robin: rr points at port1 after T1
    g0 = grant_log.size();
    fork
      begin issue(0, 32'h110, 1'b0, '0); issue(0, 32'h114, 1'b0, '0); end
      begin issue(1, 32'h1110, 1'b0, '0); issue(1, 32'h1114, 1'b0, '0); end
    join
    chk("t2_g0", grant_log[g0],   1);
    chk("t2_g1", grant_log[g0+1], 0);
    chk("t2_g2", grant_log[g0+2], 1);
    chk("t2_g3", grant_log[g0+3], 0);
    for (int i = 0; i < 4; i++) respond(32'h22220000 + 32'(i));
    step(3);

    // move rr to port0 so the lock is what keeps port1 selected
    issue(1, 32'h1200, 1'b0, '0);
    respond(32'h12001200);
    step(2);

    // T3 backpressure lock
    g0 = grant_log.size();
    bus.mem_req_ready = 1'b0;
    tb_vld[1] = 1'b1; tb_addr[1] = 32'h1300; tb_wen[1] = 1'b0;
    @(negedge clk);
    chk("t3_addr_c1", bus.mem_req_addr, 32'h1300);
    chk("t3_ready_c1", bus.req_ready, 0);
    step(1);
    tb_vld[0] = 1'b1; tb_addr[0] = 32'h300; tb_wen[0] = 1'b0;
    @(negedge clk);
    chk("t3_addr_c2", bus.mem_req_addr, 32'h1300);
    step(1);
    @(negedge clk);
    chk("t3_addr_c3", bus.mem_req_addr, 32'h1300);
    step(1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready_p1", bus.req_ready, 2'b10);
    step(1);
    tb_vld[1] = 1'b0;
    @(negedge clk);
    chk("t3_ready_p0", bus.req_ready, 2'b01);
    chk("t3_addr_p0", bus.mem_req_addr, 32'h300);
    step(1);
    tb_vld[0] = 1'b0;
    respond(32'h13131313);
    respond(32'h03030303);
    step(3);

    // T4 full
    for (int i = 0; i < 4; i++) issue(0, 32'h400 + 32'(4*i), 1'b0, '0);
    tb_vld[0] = 1'b1; tb_addr[0] = 32'h410; tb_wen[0] = 1'b0;
    @(negedge clk);
    chk("t4_outstanding", bus.outstanding, 4);
    chk("t4_blocked", bus.mem_req_valid, 0);
    step(1);
    tb_vld[1] = 1'b1; tb_addr[1] = 32'h1500; tb_wen[1] = 1'b1; tb_wd[1] = 32'h77;
    @(negedge clk);
    chk("t4_wr_blocked", bus.mem_req_valid, 0);
    chk("t4_wr_ready", bus.req_ready, 0);
    step(1);
    tb_vld[1] = 1'b0; tb_wen[1] = 1'b0;
    push_resp(32'h44440000);
    @(negedge clk);
    chk("t4_pop_no_unblock", bus.mem_req_valid, 0);
    step(1);
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("t4_resume_ready", bus.req_ready, 2'b01);
    chk("t4_out_after_pop", bus.outstanding, 3);
    step(1);
    tb_vld[0] = 1'b0;
    @(negedge clk);
    chk("t4_out_refill", bus.outstanding, 4);
    step(1);
    for (int i = 1; i < 5; i++) respond(32'h44440000 + 32'(i));
    step(3);

    // T5 writes interleaved with reads; rr points at port1
    g0 = grant_log.size();
    fork
      begin issue(0, 32'h200, 1'b1, 32'h55); end
      begin issue(1, 32'h1600, 1'b0, '0); issue(1, 32'h1604, 1'b0, '0); end
    join
    @(negedge clk);
    chk("t5_outstanding", bus.outstanding, 2);
    chk("t5_wr_count", wr_addr_log.size(), 1);
    chk("t5_wr_addr", wr_addr_log[0], 32'h200);
    chk("t5_wr_data", wr_data_log[0], 32'h55);
    chk("t5_g0", grant_log[g0],   1);
    chk("t5_g1", grant_log[g0+1], 0);
    chk("t5_g2", grant_log[g0+2], 1);
    step(1);
    respond(32'h16000000);
    respond(32'h16040000);
    step(3);

    // T6 stray response while idle
    chk("t6_err_before", bus.err, 0);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hBAD0BAD0;
    step(1);
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("t6_err", bus.err, 1);
    chk("t6_no_resp", bus.resp_valid, 0);
    step(1);

    // T6 reset mid-burst with 3 outstanding
    for (int i = 0; i < 3; i++) issue(0, 32'h700 + 32'(4*i), 1'b0, '0);
    @(negedge clk);
    chk("t6_out3", bus.outstanding, 3);
    step(1);
    tb_vld[0] = 1'b1; tb_addr[0] = 32'h70C; tb_wen[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", bus.outstanding, 0);
    chk("t6_rst_ready", bus.req_ready, 0);
    chk("t6_rst_memvalid", bus.mem_req_valid, 0);
    chk("t6_rst_err", bus.err, 0);
    issued.delete();
    tb_vld[0] = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
